// File: rtl/fp32_multiplier.sv
// Pipelined binary32 multiplier: result on f 3 enabled edges after operands are sampled; exception flags NaN/invalid/overflow.
// start=0 freezes every stage, including f/exception; no internal backpressure.
// Optional output port `valid` when FP_MUL_VALID_OUT_EN is defined.
module fp32_multiplier (
    input  logic        clk,
    input  logic        start,
    input  logic        clrn,
    input  logic [31:0] d,
    input  logic [31:0] e,
    output logic [31:0] f,
    output logic        exception
`ifdef FP_MUL_VALID_OUT_EN
    ,
    output logic        valid
`endif
);

    typedef struct packed {
        logic               sign;
        logic               nan;
        logic               inf;
        logic               zero;
        logic signed [9:0]  exp;
        logic [47:0]        prod;
    } s1_t;

    typedef struct packed {
        logic               sign;
        logic               nan;
        logic               inf;
        logic               zero;
        logic signed [9:0]  exp;
        logic [22:0]        mant;
        logic               g;
        logic               r;
        logic               s;
    } s2_t;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    // Stage 1: unpack, classify (subnormals count as zero), exponent sum and significand product.
    always_comb begin
        ea     = d[30:23];
        eb     = e[30:23];
        fa     = d[22:0];
        fb     = e[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        a_zero = (ea == 8'h00);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        b_zero = (eb == 8'h00);

        s1_d      = '0;
        s1_d.sign = d[31] ^ e[31];
        s1_d.nan  = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
        s1_d.inf  = (a_inf | b_inf) & ~s1_d.nan;
        s1_d.zero = (a_zero | b_zero) & ~s1_d.nan & ~s1_d.inf;
        s1_d.exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        s1_d.prod = 48'({1'b1, fa}) * 48'({1'b1, fb});
    end

    // Stage 2: normalize so the leading one sits just above the 23 kept fraction bits.
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.nan  = s1_q.nan;
        s2_d.inf  = s1_q.inf;
        s2_d.zero = s1_q.zero;
        if (s1_q.prod[47]) begin
            s2_d.exp  = s1_q.exp + 10'sd1;
            s2_d.mant = s1_q.prod[46:24];
            s2_d.g    = s1_q.prod[23];
            s2_d.r    = s1_q.prod[22];
            s2_d.s    = |s1_q.prod[21:0];
        end else begin
            s2_d.exp  = s1_q.exp;
            s2_d.mant = s1_q.prod[45:23];
            s2_d.g    = s1_q.prod[22];
            s2_d.r    = s1_q.prod[21];
            s2_d.s    = |s1_q.prod[20:0];
        end
    end

    logic              round_up;
    logic [23:0]       mant_r;
    logic signed [9:0] exp_r;
    logic [31:0]       f_d;
    logic              exc_d;

    // Stage 3: round to nearest even; a carry out of the fraction leaves it all-zero and bumps the exponent.
    always_comb begin
        round_up = s2_q.g & (s2_q.r | s2_q.s | s2_q.mant[0]);
        mant_r   = {1'b0, s2_q.mant} + {23'd0, round_up};
        exp_r    = s2_q.exp + (mant_r[23] ? 10'sd1 : 10'sd0);
        f_d      = {s2_q.sign, exp_r[7:0], mant_r[22:0]};
        exc_d    = 1'b0;
        if (s2_q.nan) begin
            f_d   = 32'h7FC0_0000;
            exc_d = 1'b1;
        end else if (s2_q.inf) begin
            f_d = {s2_q.sign, 8'hFF, 23'd0};
        end else if (s2_q.zero) begin
            f_d = {s2_q.sign, 31'd0};
        end else if (exp_r >= 10'sd255) begin
            f_d   = {s2_q.sign, 8'hFF, 23'd0};
            exc_d = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            f_d = {s2_q.sign, 31'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            f         <= 32'h0000_0000;
            exception <= 1'b0;
        end else if (start) begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            f         <= f_d;
            exception <= exc_d;
        end
    end

`ifdef FP_MUL_VALID_OUT_EN
    logic v1_q, v2_q;

    always_ff @(posedge clk) begin
        if (clrn) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            valid <= 1'b0;
        end else if (start) begin
            v1_q  <= 1'b1;
            v2_q  <= v1_q;
            valid <= v2_q;
        end
    end
`endif

endmodule

// File: tb/tb_fp32_multiplier.sv
// Bench for fp32_multiplier: double-precision reference model plus a 3-slot transaction pipe,
// compared against the DUT on every cycle; literal vectors pin the model and the DUT.
module tb_fp32_multiplier;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [31:0] d, e;
    logic [31:0] f;
    logic        exception;
`ifdef FP_MUL_VALID_OUT_EN
    logic        valid;
`endif

    always #5 clk = ~clk;

    fp32_multiplier dut (
        .clk       (clk),
        .start     (start),
        .clrn      (clrn),
        .d         (d),
        .e         (e),
        .f         (f),
        .exception (exception)
`ifdef FP_MUL_VALID_OUT_EN
        ,
        .valid     (valid)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: exact product in double precision, then RNE rounding from the double's bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic x);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        bit          an, ai, az, bn, bi, bz;
        real         ra, rb, p;
        logic [63:0] bits;
        int          de, e32;
        logic [22:0] keep;
        logic [28:0] rem;
        logic [23:0] m;
        bit          up;
        s  = a[31] ^ b[31];
        ea = a[30:23]; fa = a[22:0];
        eb = b[30:23]; fb = b[22:0];
        an = (ea == 8'hFF) && (fa != 0); ai = (ea == 8'hFF) && (fa == 0); az = (ea == 0);
        bn = (eb == 8'hFF) && (fb != 0); bi = (eb == 8'hFF) && (fb == 0); bz = (eb == 0);
        x = 1'b0;
        if (an || bn || (ai && bz) || (az && bi)) begin
            r = 32'h7FC0_0000;
            x = 1'b1;
        end else if (ai || bi) begin
            r = {s, 8'hFF, 23'd0};
        end else if (az || bz) begin
            r = {s, 31'd0};
        end else begin
            ra   = $bitstoreal({1'b0, 11'(ea) + 11'd896, fa, 29'd0});
            rb   = $bitstoreal({1'b0, 11'(eb) + 11'd896, fb, 29'd0});
            p    = ra * rb;
            bits = $realtobits(p);
            de   = int'(bits[62:52]) - 1023;
            keep = bits[51:29];
            rem  = bits[28:0];
            up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
            m    = {1'b0, keep} + {23'd0, up};
            if (m[23]) de++;
            e32  = de + 127;
            if (e32 >= 255) begin
                r = {s, 8'hFF, 23'd0};
                x = 1'b1;
            end else if (e32 <= 0) begin
                r = {s, 31'd0};
            end else begin
                r = {s, 8'(e32), m[22:0]};
            end
        end
    endfunction

    // Transaction-level pipe: slot 2 is what f/exception must show.
    logic [31:0] pf [3];
    logic        px [3];
    logic        pv [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            pf[i] = '0; px[i] = 1'b0; pv[i] = 1'b0;
        end
    end

    always @(posedge clk) begin : ref_pipe
        logic [31:0] rf;
        logic        rx;
        if (clrn) begin
            for (int i = 0; i < 3; i++) begin
                pf[i] <= '0; px[i] <= 1'b0; pv[i] <= 1'b0;
            end
        end else if (start) begin
            model(d, e, rf, rx);
            pf[0] <= rf;    px[0] <= rx;    pv[0] <= 1'b1;
            pf[1] <= pf[0]; px[1] <= px[0]; pv[1] <= pv[0];
            pf[2] <= pf[1]; px[2] <= px[1]; pv[2] <= pv[1];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("f", f, pf[2]);
            check("exception", {31'd0, exception}, {31'd0, px[2]});
`ifdef FP_MUL_VALID_OUT_EN
            check("valid", {31'd0, valid}, {31'd0, pv[2]});
`endif
        end
    end

    task automatic model_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] wf, input logic wx);
        logic [31:0] rf;
        logic        rx;
        model(a, b, rf, rx);
        check({name, "_model_f"}, rf, wf);
        check({name, "_model_x"}, {31'd0, rx}, {31'd0, wx});
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic st);
        @(negedge clk);
        d = a; e = b; start = st; clrn = 1'b0;
    endtask

    // Present one operand pair, let it flow 3 enabled edges, check the literal answer.
    task automatic dut_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] wf, input logic wx);
        drive(a, b, 1'b1);
        drive(32'd0, 32'd0, 1'b1);
        drive(32'd0, 32'd0, 1'b1);
        @(negedge clk);
        check({name, "_dut_f"}, f, wf);
        check({name, "_dut_x"}, {31'd0, exception}, {31'd0, wx});
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b1; start = 1'b1; d = 32'h3F80_0000; e = 32'h4000_0000;
        @(negedge clk);
        clrn = 1'b0;
        chk_en = 1'b1;
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  ex;
        logic [22:0] fr;
        int          sel;
        sel = $urandom_range(0, 9);
        fr  = 23'($urandom);
        case (sel)
            0:       ex = 8'h00;
            1:       ex = 8'hFF;
            2, 3:    ex = 8'($urandom_range(124, 130));
            4:       ex = 8'($urandom_range(190, 254));
            5:       ex = 8'($urandom_range(1, 60));
            default: ex = 8'($urandom_range(1, 254));
        endcase
        if ($urandom_range(0, 5) == 0) fr = 23'd0;
        return {1'($urandom), ex, fr};
    endfunction

    initial begin
        clrn = 1'b1; start = 1'b0; d = '0; e = '0;

        model_lit("ovf",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1);
        model_lit("mixed", 32'h4306_1000, 32'hC010_0000, 32'hC396_D200, 1'b0);
        model_lit("negneg",32'hC168_0000, 32'hBEC0_0000, 32'h40AE_0000, 1'b0);
        model_lit("b2b",   32'h40F0_0000, 32'h4178_0000, 32'h42E8_8000, 1'b0);
        model_lit("infz",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1);
        model_lit("ninf",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0);
        model_lit("subn",  32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0);
        model_lit("rne",   32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0);

        do_reset();
        check("reset_f", f, 32'h0);
        check("reset_x", {31'd0, exception}, 32'd0);

        dut_lit("ovf",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1);
        dut_lit("mixed", 32'h4306_1000, 32'hC010_0000, 32'hC396_D200, 1'b0);
        dut_lit("infz",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1);
        dut_lit("ninf",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0);
        dut_lit("subn",  32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0);
        dut_lit("rne",   32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0);

        // Back-to-back pair, then a stall in the middle of a stream.
        drive(32'hC168_0000, 32'hBEC0_0000, 1'b1);
        drive(32'h40F0_0000, 32'h4178_0000, 1'b1);
        drive(32'h4306_1000, 32'hC010_0000, 1'b1);
        drive(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0);
        drive(32'h3F80_0001, 32'h3F80_0001, 1'b0);
        drive(32'h3F80_0001, 32'h3F80_0001, 1'b1);
        drive(32'h0, 32'h0, 1'b1);
        drive(32'h0, 32'h0, 1'b0);
        drive(32'h0, 32'h0, 1'b1);
        drive(32'h0, 32'h0, 1'b1);

        // Random traffic with random stalls and occasional mid-stream reset.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            d     = rand_op();
            e     = rand_op();
            start = ($urandom_range(0, 9) < 8);
            clrn  = ($urandom_range(0, 99) == 0);
        end
        drive(32'h0, 32'h0, 1'b1);
        drive(32'h0, 32'h0, 1'b1);
        drive(32'h0, 32'h0, 1'b1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
